// File: rtl/rx_eth_dispatch.sv
// GMII receive front end: preamble/SFD detect, MAC filter, ethertype dispatch, FCS-stripped payload.
// Define RX_ETH_FCS_CHECK_EN to add CRC-32 checking of the received FCS.
module rx_eth_dispatch #(
  parameter int unsigned           OCT     = 8,
  parameter logic [OCT-1:0]        PRE     = 8'h55,
  parameter logic [OCT-1:0]        SFD     = 8'hD5,
  parameter int unsigned           N_CH    = 2,
  parameter logic [N_CH*16-1:0]    ETYPES  = {16'h0806, 16'h0800},
  parameter int unsigned           MAX_LEN = 1500,
  parameter int unsigned           CNT_W   = 16
) (
  input  logic             RX_CLK,
  input  logic             rst,
  input  logic [47:0]      mac_addr,
  input  logic             RX_DV,
  input  logic [OCT-1:0]   RXD,
  input  logic             RX_ER,
  output logic [OCT-1:0]   rx_payload,
  output logic             rx_payload_valid,
  output logic             rx_sof,
  output logic [N_CH-1:0]  rx_ch_sel,
  output logic             rx_done,
  output logic             rx_err,
  output logic [CNT_W-1:0] rx_drop_cnt
);

  localparam logic [10:0] PayOvl = 11'(MAX_LEN + 4);
  // 64-byte minimum frame less the 14 header bytes; also covers an incomplete FCS
  localparam logic [10:0] MinPay = 11'd50;

  typedef enum logic [2:0] {StIdle, StPre, StHdr, StPay, StDrop, StStat} state_e;

  state_e            state_q, state_d;
  logic              dv_q, start, fcs_bad, hit;
  logic [3:0]        hdr_cnt_q, hdr_cnt_d;
  logic [10:0]       pay_cnt_q, pay_cnt_d;
  logic              dst_own_q, dst_own_d, dst_bc_q, dst_bc_d;
  logic [OCT-1:0]    type_hi_q, type_hi_d;
  logic [OCT-1:0]    dl_q [4];
  logic [OCT-1:0]    dl_d [4];
  logic [OCT-1:0]    mac_b [8];
  logic              err_q, err_d, ovl_q, ovl_d;
  logic [OCT-1:0]    payload_q, payload_d;
  logic              valid_q, valid_d, sof_q, sof_d, done_q, done_d, rx_err_q, rx_err_d;
  logic [N_CH-1:0]   ch_sel_q, ch_sel_d, sel;
  logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;

  assign start = RX_DV & ~dv_q;

  always_comb begin
    for (int i = 0; i < 6; i++) mac_b[i] = mac_addr[OCT*(5-i) +: OCT];
    mac_b[6] = '0;
    mac_b[7] = '0;
  end

  always_comb begin
    state_d    = state_q;
    hdr_cnt_d  = hdr_cnt_q;
    pay_cnt_d  = pay_cnt_q;
    dst_own_d  = dst_own_q;
    dst_bc_d   = dst_bc_q;
    type_hi_d  = type_hi_q;
    err_d      = err_q;
    ovl_d      = ovl_q;
    for (int i = 0; i < 4; i++) dl_d[i] = dl_q[i];
    payload_d  = payload_q;
    valid_d    = 1'b0;
    sof_d      = 1'b0;
    ch_sel_d   = ch_sel_q;
    done_d     = 1'b0;
    rx_err_d   = 1'b0;
    drop_cnt_d = drop_cnt_q;
    hit        = 1'b0;
    sel        = '0;
    unique case (state_q)
      StIdle, StStat: begin
        ch_sel_d = '0;
        state_d  = StIdle;
        if (start && RXD == PRE)      state_d = StPre;
        else if (start && RXD == SFD) state_d = StHdr;
      end
      StPre: begin
        if (!RX_DV)          state_d = StIdle;
        else if (RXD == SFD) state_d = StHdr;
        else if (RXD != PRE) state_d = StIdle;
      end
      StHdr: begin
        if (!RX_DV) begin
          state_d = StIdle;
        end else begin
          if (RX_ER) err_d = 1'b1;
          if (hdr_cnt_q < 4'd6) begin
            dst_own_d = dst_own_q & (RXD == mac_b[hdr_cnt_q[2:0]]);
            dst_bc_d  = dst_bc_q & (RXD == '1);
          end
          if (hdr_cnt_q == 4'd12) type_hi_d = RXD;
          if (hdr_cnt_q == 4'd13) begin
            // Descending scan so the lowest matching entry wins
            for (int i = N_CH - 1; i >= 0; i--) begin
              if ({type_hi_q, RXD} == ETYPES[16*i +: 16]) begin
                hit    = 1'b1;
                sel    = '0;
                sel[i] = 1'b1;
              end
            end
            if ((dst_own_q || dst_bc_q) && hit) begin
              state_d   = StPay;
              ch_sel_d  = sel;
              pay_cnt_d = '0;
            end else begin
              state_d = StDrop;
              if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + 1'b1;
            end
          end else begin
            hdr_cnt_d = hdr_cnt_q + 4'd1;
          end
        end
      end
      StPay: begin
        if (!RX_DV) begin
          state_d  = StStat;
          done_d   = 1'b1;
          rx_err_d = err_q | (pay_cnt_q < MinPay) | fcs_bad;
        end else begin
          if (RX_ER) err_d = 1'b1;
          if (pay_cnt_q >= PayOvl) begin
            err_d   = 1'b1;
            ovl_d   = 1'b1;
            state_d = StDrop;
          end else begin
            dl_d[0] = RXD;
            for (int i = 1; i < 4; i++) dl_d[i] = dl_q[i-1];
            pay_cnt_d = pay_cnt_q + 11'd1;
            // Four bytes held back so the trailing FCS is never emitted
            if (pay_cnt_q >= 11'd4) begin
              payload_d = dl_q[3];
              valid_d   = 1'b1;
              sof_d     = (pay_cnt_q == 11'd4);
            end
          end
        end
      end
      StDrop: begin
        if (!RX_DV) begin
          if (ovl_q) begin
            state_d  = StStat;
            done_d   = 1'b1;
            rx_err_d = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    if (state_d == StHdr && state_q != StHdr) begin
      hdr_cnt_d = '0;
      dst_own_d = 1'b1;
      dst_bc_d  = 1'b1;
      err_d     = 1'b0;
      ovl_d     = 1'b0;
    end
  end

`ifdef RX_ETH_FCS_CHECK_EN
  logic [31:0] crc_q, crc_d, crc_rev;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [OCT-1:0] b);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < OCT; i++) r = (r[0] ^ b[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  always_comb begin
    crc_d = crc_q;
    if (state_d == StHdr && state_q != StHdr) crc_d = '1;
    else if (RX_DV && (state_q == StHdr || state_q == StPay)) crc_d = crc_byte(crc_q, RXD);
    for (int i = 0; i < 32; i++) crc_rev[i] = crc_q[31-i];
  end

  assign fcs_bad = (crc_rev != 32'hC704DD7B);

  always_ff @(posedge RX_CLK or negedge rst) begin
    if (!rst) crc_q <= '1;
    else      crc_q <= crc_d;
  end
`else
  assign fcs_bad = 1'b0;
`endif

  always_ff @(posedge RX_CLK or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      dv_q       <= 1'b1;
      hdr_cnt_q  <= '0;
      pay_cnt_q  <= '0;
      dst_own_q  <= 1'b0;
      dst_bc_q   <= 1'b0;
      type_hi_q  <= '0;
      for (int i = 0; i < 4; i++) dl_q[i] <= '0;
      err_q      <= 1'b0;
      ovl_q      <= 1'b0;
      payload_q  <= '0;
      valid_q    <= 1'b0;
      sof_q      <= 1'b0;
      ch_sel_q   <= '0;
      done_q     <= 1'b0;
      rx_err_q   <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      dv_q       <= RX_DV;
      hdr_cnt_q  <= hdr_cnt_d;
      pay_cnt_q  <= pay_cnt_d;
      dst_own_q  <= dst_own_d;
      dst_bc_q   <= dst_bc_d;
      type_hi_q  <= type_hi_d;
      for (int i = 0; i < 4; i++) dl_q[i] <= dl_d[i];
      err_q      <= err_d;
      ovl_q      <= ovl_d;
      payload_q  <= payload_d;
      valid_q    <= valid_d;
      sof_q      <= sof_d;
      ch_sel_q   <= ch_sel_d;
      done_q     <= done_d;
      rx_err_q   <= rx_err_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign rx_payload       = payload_q;
  assign rx_payload_valid = valid_q;
  assign rx_sof           = sof_q;
  assign rx_ch_sel        = ch_sel_q;
  assign rx_done          = done_q;
  assign rx_err           = rx_err_q;
  assign rx_drop_cnt      = drop_cnt_q;

endmodule

// File: tb/tb_rx_eth_dispatch.sv
// Directed bench for rx_eth_dispatch; a second instance with a 3-bit drop counter covers saturation.
module tb_rx_eth_dispatch;

  localparam logic [47:0] MAC   = 48'h02_00_00_00_00_01;
  localparam logic [47:0] BCAST = 48'hFF_FF_FF_FF_FF_FF;
  localparam logic [47:0] OTHER = 48'h02_00_00_00_00_99;

  logic        RX_CLK = 1'b0;
  logic        rst, RX_DV, RX_ER;
  logic [7:0]  RXD;
  logic [7:0]  rx_payload;
  logic        rx_payload_valid, rx_sof, rx_done, rx_err;
  logic [1:0]  rx_ch_sel;
  logic [15:0] rx_drop_cnt;
  logic [7:0]  s_payload;
  logic        s_valid, s_sof, s_done, s_err;
  logic [1:0]  s_ch_sel;
  logic [2:0]  s_drop_cnt;

  rx_eth_dispatch u_dut (
    .RX_CLK(RX_CLK), .rst(rst), .mac_addr(MAC), .RX_DV(RX_DV), .RXD(RXD), .RX_ER(RX_ER),
    .rx_payload(rx_payload), .rx_payload_valid(rx_payload_valid), .rx_sof(rx_sof),
    .rx_ch_sel(rx_ch_sel), .rx_done(rx_done), .rx_err(rx_err), .rx_drop_cnt(rx_drop_cnt)
  );

  rx_eth_dispatch #(.CNT_W(3)) u_sat (
    .RX_CLK(RX_CLK), .rst(rst), .mac_addr(MAC), .RX_DV(RX_DV), .RXD(RXD), .RX_ER(RX_ER),
    .rx_payload(s_payload), .rx_payload_valid(s_valid), .rx_sof(s_sof),
    .rx_ch_sel(s_ch_sel), .rx_done(s_done), .rx_err(s_err), .rx_drop_cnt(s_drop_cnt)
  );

  always #5 RX_CLK = ~RX_CLK;

  int         checks = 0, failures = 0;
  int         exp_drop = 0;
  logic [7:0] frm[$];
  logic [7:0] got[$];
  logic       done_errs[$];
  int         sof_cnt, sof_idx, done_cnt;
  logic [1:0] ch_at_sof, ch_at_done;

  always @(negedge RX_CLK) begin
    if (rx_payload_valid) begin
      if (rx_sof) begin
        if (sof_cnt == 0) begin
          sof_idx   = got.size();
          ch_at_sof = rx_ch_sel;
        end
        sof_cnt++;
      end
      got.push_back(rx_payload);
    end
    if (rx_done) begin
      done_cnt++;
      ch_at_done = rx_ch_sel;
      done_errs.push_back(rx_err);
    end
  end

  task automatic mon_clear();
    got.delete();
    done_errs.delete();
    sof_cnt = 0; sof_idx = -1; done_cnt = 0;
    ch_at_sof = 2'b00; ch_at_done = 2'b00;
  endtask

  task automatic build_frame(input logic [47:0] dst, input logic [15:0] et, input int n,
                             input int pad);
    logic [31:0] c;
    frm.delete();
    for (int i = 0; i < 6; i++) frm.push_back(dst[47-8*i -: 8]);
    for (int i = 0; i < 6; i++) frm.push_back(8'(8'hA0 + i));
    frm.push_back(et[15:8]);
    frm.push_back(et[7:0]);
    for (int i = 0; i < n; i++) frm.push_back(8'(i));
    for (int i = 0; i < pad; i++) frm.push_back(8'h00);
    c = 32'hFFFF_FFFF;
    foreach (frm[k]) begin
      c = c ^ {24'h0, frm[k]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    c = ~c;
    for (int i = 0; i < 4; i++) frm.push_back(c[8*i +: 8]);
  endtask

  task automatic drive_byte(input logic dv, input logic [7:0] d, input logic er);
    @(posedge RX_CLK);
    #1;
    RX_DV = dv; RXD = d; RX_ER = er;
  endtask

  task automatic send_frame(input int er_idx, input int ifg);
    for (int i = 0; i < 7; i++) drive_byte(1'b1, 8'h55, 1'b0);
    drive_byte(1'b1, 8'hD5, 1'b0);
    for (int i = 0; i < frm.size(); i++) drive_byte(1'b1, frm[i], i == er_idx);
    for (int i = 0; i < ifg; i++) drive_byte(1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b0; RX_DV = 1'b0; RXD = 8'h00; RX_ER = 1'b0;
    repeat (3) @(posedge RX_CLK);
    #2;
    checks++; if (rx_payload_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", rx_payload_valid); end
    checks++; if (rx_sof !== 1'b0) begin failures++; $display("FAIL reset_sof got=%b exp=0", rx_sof); end
    checks++; if (rx_ch_sel !== 2'b00) begin failures++; $display("FAIL reset_ch_sel got=%b exp=00", rx_ch_sel); end
    checks++; if (rx_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", rx_done); end
    checks++; if (rx_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", rx_err); end
    checks++; if (rx_drop_cnt !== 16'h0) begin failures++; $display("FAIL reset_drop_cnt got=%0d exp=0", rx_drop_cnt); end
    checks++; if (rx_payload !== 8'h00) begin failures++; $display("FAIL reset_payload got=%h exp=00", rx_payload); end
    rst = 1'b1;
    repeat (3) drive_byte(1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_unicast();
    int bad = 0;
    mon_clear();
    build_frame(MAC, 16'h0800, 46, 0);
    send_frame(-1, 6);
    for (int i = 0; i < got.size() && i < 46; i++) if (got[i] !== 8'(i)) bad++;
    checks++; if (got.size() !== 46) begin failures++; $display("FAIL uni_len got=%0d exp=46", got.size()); end
    checks++; if (bad !== 0) begin failures++; $display("FAIL uni_data bad_bytes=%0d exp=0", bad); end
    checks++; if (sof_cnt !== 1 || sof_idx !== 0) begin failures++; $display("FAIL uni_sof cnt=%0d idx=%0d exp=1,0", sof_cnt, sof_idx); end
    checks++; if (ch_at_sof !== 2'b01 || ch_at_done !== 2'b01) begin failures++; $display("FAIL uni_ch_sel sof=%b done=%b exp=01", ch_at_sof, ch_at_done); end
    checks++; if (done_cnt !== 1) begin failures++; $display("FAIL uni_done got=%0d exp=1", done_cnt); end
    checks++; if (done_errs.size() != 1 || done_errs[0] !== 1'b0) begin failures++; $display("FAIL uni_err got=%0d entries exp=one 0", done_errs.size()); end
  endtask

  task automatic test_broadcast_filter();
    int bad = 0;
    mon_clear();
    build_frame(BCAST, 16'h0806, 28, 18);
    send_frame(-1, 6);
    for (int i = 0; i < got.size() && i < 46; i++) if (got[i] !== ((i < 28) ? 8'(i) : 8'h00)) bad++;
    checks++; if (got.size() !== 46) begin failures++; $display("FAIL bc_len got=%0d exp=46", got.size()); end
    checks++; if (bad !== 0) begin failures++; $display("FAIL bc_data bad_bytes=%0d exp=0", bad); end
    checks++; if (ch_at_sof !== 2'b10) begin failures++; $display("FAIL bc_ch_sel got=%b exp=10", ch_at_sof); end
    checks++; if (done_cnt !== 1 || done_errs.size() != 1 || done_errs[0] !== 1'b0) begin failures++; $display("FAIL bc_done cnt=%0d exp=1 with err 0", done_cnt); end
    mon_clear();
    build_frame(OTHER, 16'h0800, 46, 0);
    send_frame(-1, 6);
    exp_drop++;
    checks++; if (got.size() !== 0 || done_cnt !== 0) begin failures++; $display("FAIL mac_filter bytes=%0d done=%0d exp=0,0", got.size(), done_cnt); end
    checks++; if (rx_drop_cnt !== 16'(exp_drop)) begin failures++; $display("FAIL mac_drop_cnt got=%0d exp=%0d", rx_drop_cnt, exp_drop); end
  endtask

  task automatic test_drop_sat();
    mon_clear();
    build_frame(MAC, 16'h86DD, 46, 0);
    send_frame(-1, 6);
    exp_drop++;
    checks++; if (got.size() !== 0 || done_cnt !== 0) begin failures++; $display("FAIL type_filter bytes=%0d done=%0d exp=0,0", got.size(), done_cnt); end
    checks++; if (rx_drop_cnt !== 16'(exp_drop)) begin failures++; $display("FAIL type_drop_cnt got=%0d exp=%0d", rx_drop_cnt, exp_drop); end
    build_frame(MAC, 16'h86DD, 0, 0);
    for (int i = 0; i < 7; i++) begin
      send_frame(-1, 3);
      exp_drop++;
    end
    checks++; if (rx_drop_cnt !== 16'(exp_drop)) begin failures++; $display("FAIL drop_cnt_many got=%0d exp=%0d", rx_drop_cnt, exp_drop); end
    checks++; if (s_drop_cnt !== 3'd7) begin failures++; $display("FAIL drop_cnt_sat got=%0d exp=7", s_drop_cnt); end
  endtask

  task automatic test_rx_er_runt();
    mon_clear();
    build_frame(MAC, 16'h0800, 46, 0);
    send_frame(24, 6);
    checks++; if (got.size() !== 46) begin failures++; $display("FAIL er_len got=%0d exp=46", got.size()); end
    checks++; if (done_cnt !== 1) begin failures++; $display("FAIL er_done got=%0d exp=1", done_cnt); end
    checks++; if (done_errs.size() != 1 || done_errs[0] !== 1'b1) begin failures++; $display("FAIL er_err entries=%0d exp=one 1", done_errs.size()); end
    mon_clear();
    build_frame(MAC, 16'h0800, 22, 0);
    send_frame(-1, 6);
    checks++; if (got.size() !== 22) begin failures++; $display("FAIL runt_len got=%0d exp=22", got.size()); end
    checks++; if (done_cnt !== 1) begin failures++; $display("FAIL runt_done got=%0d exp=1", done_cnt); end
    checks++; if (done_errs.size() != 1 || done_errs[0] !== 1'b1) begin failures++; $display("FAIL runt_err entries=%0d exp=one 1", done_errs.size()); end
  endtask

  task automatic test_overlength_back_to_back();
    int bad = 0;
    mon_clear();
    build_frame(MAC, 16'h0800, 1501, 0);
    send_frame(-1, 1);
    build_frame(MAC, 16'h0800, 46, 0);
    send_frame(-1, 6);
    for (int i = 0; i < got.size() && i < 1546; i++)
      if (got[i] !== ((i < 1500) ? 8'(i) : 8'(i - 1500))) bad++;
    checks++; if (got.size() !== 1546) begin failures++; $display("FAIL ovl_b2b_len got=%0d exp=1546", got.size()); end
    checks++; if (bad !== 0) begin failures++; $display("FAIL ovl_b2b_data bad_bytes=%0d exp=0", bad); end
    checks++; if (sof_cnt !== 2) begin failures++; $display("FAIL b2b_sof got=%0d exp=2", sof_cnt); end
    checks++; if (done_cnt !== 2) begin failures++; $display("FAIL ovl_b2b_done got=%0d exp=2", done_cnt); end
    checks++; if (done_errs.size() != 2 || done_errs[0] !== 1'b1) begin failures++; $display("FAIL ovl_err entries=%0d exp=first 1", done_errs.size()); end
    checks++; if (done_errs.size() != 2 || done_errs[1] !== 1'b0) begin failures++; $display("FAIL b2b_err entries=%0d exp=second 0", done_errs.size()); end
  endtask

  task automatic test_fcs();
    logic exp_err;
`ifdef RX_ETH_FCS_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    mon_clear();
    build_frame(MAC, 16'h0800, 46, 0);
    frm[frm.size()-1] = frm[frm.size()-1] ^ 8'h10;
    send_frame(-1, 6);
    checks++; if (got.size() !== 46) begin failures++; $display("FAIL fcs_len got=%0d exp=46", got.size()); end
    checks++; if (done_errs.size() != 1 || done_errs[0] !== exp_err) begin failures++; $display("FAIL fcs_err entries=%0d exp=one %b", done_errs.size(), exp_err); end
  endtask

  task automatic test_reset_mid();
    int bad = 0;
    mon_clear();
    build_frame(MAC, 16'h0800, 46, 0);
    for (int i = 0; i < 7; i++) drive_byte(1'b1, 8'h55, 1'b0);
    drive_byte(1'b1, 8'hD5, 1'b0);
    for (int i = 0; i < frm.size(); i++) begin
      drive_byte(1'b1, frm[i], 1'b0);
      if (i == 34) begin
        checks++; if (rx_payload_valid !== 1'b1) begin failures++; $display("FAIL pre_rst_valid got=%b exp=1", rx_payload_valid); end
        #2 rst = 1'b0;
        #1;
        checks++; if (rx_payload_valid !== 1'b0 || rx_ch_sel !== 2'b00 || rx_payload !== 8'h00) begin
          failures++; $display("FAIL rst_async valid=%b ch=%b data=%h exp=0,00,00", rx_payload_valid, rx_ch_sel, rx_payload); end
        #2 rst = 1'b1;
        mon_clear();
      end
    end
    repeat (6) drive_byte(1'b0, 8'h00, 1'b0);
    checks++; if (got.size() !== 0 || done_cnt !== 0) begin failures++; $display("FAIL rst_ignore bytes=%0d done=%0d exp=0,0", got.size(), done_cnt); end
    checks++; if (rx_drop_cnt !== 16'h0) begin failures++; $display("FAIL rst_drop_cnt got=%0d exp=0", rx_drop_cnt); end
    mon_clear();
    send_frame(-1, 6);
    for (int i = 0; i < got.size() && i < 46; i++) if (got[i] !== 8'(i)) bad++;
    checks++; if (got.size() !== 46 || bad !== 0) begin failures++; $display("FAIL post_rst_frame len=%0d bad=%0d exp=46,0", got.size(), bad); end
    checks++; if (done_errs.size() != 1 || done_errs[0] !== 1'b0) begin failures++; $display("FAIL post_rst_err entries=%0d exp=one 0", done_errs.size()); end
  endtask

  initial begin
    mon_clear();
    test_reset();
    test_unicast();
    test_broadcast_filter();
    test_drop_sat();
    test_rx_er_runt();
    test_overlength_back_to_back();
    test_fcs();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
